// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Start-triggered sequencer that reads a contiguous run of weight words from a
// synchronous ROM (one-cycle read latency) and writes them, strictly in order,
// into per-node FIFOs.
//
// Word k always goes to node (k mod NUM_NODES).
//
// If the target node's FIFO is full, the whole stream stalls. No other node is
// allowed to go ahead, so the word order at each node is preserved.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   start       one-cycle request, accepted only in IDLE (and only if abort=0)
//   abort       ends a running transfer early
//   base_addr   first ROM address (latched on accepted start)
//   num_words   number of words, 0..2^ADDR_WIDTH (latched on accepted start)
//   full        per-node FIFO full flags
//   rom_en      ROM read strobe (combinational)
//   rom_addr    ROM read address (combinational, valid with rom_en)
//   rom_data    ROM read data, valid the cycle after rom_en
//   fifo_wr_en  one-hot FIFO write strobe (registered)
//   fifo_wdata  FIFO write data (rom_data passed straight through)
//   busy        high in RUN and DRAIN
//   done        one-cycle completion pulse
// -----------------------------------------------------------------------------
module weight_loader #(
    parameter int NUM_NODES  = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [NUM_NODES-1:0]  full,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [NUM_NODES-1:0]  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;
    logic [NODE_W-1:0]     node_reg, node_next;
    logic [NUM_NODES-1:0]  wr_en_reg, wr_en_next;
    logic [NUM_NODES-1:0]  node_onehot;
    logic                  issue;

    // One-hot decode of the node that the next issued word belongs to.
    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_onehot
            assign node_onehot[gi] = (node_reg == NODE_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        node_next      = node_reg;
        wr_en_next     = '0;
        issue          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    addr_next      = base_addr;
                    remaining_next = num_words;
                    node_next      = '0;
                    state_next     = (num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort || remaining_reg == '0) begin
                    state_next = DRAIN;
                end else if (!full[node_reg]) begin
                    // The write strobe is delayed one cycle so that it lines up
                    // with the ROM's read latency.
                    issue          = 1'b1;
                    addr_next      = addr_reg + ADDR_WIDTH'(1);
                    remaining_next = remaining_reg - (ADDR_WIDTH + 1)'(1);
                    node_next      = (node_reg == NODE_W'(NUM_NODES - 1)) ? '0
                                                                          : node_reg + NODE_W'(1);
                    wr_en_next     = node_onehot;
                    if (remaining_reg == (ADDR_WIDTH + 1)'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            node_reg      <= '0;
            wr_en_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            node_reg      <= node_next;
            wr_en_reg     <= wr_en_next;
        end
    end

    assign rom_en     = issue;
    assign rom_addr   = addr_reg;
    assign fifo_wr_en = wr_en_reg;
    assign fifo_wdata = rom_data;
    assign busy       = (state_reg == RUN) || (state_reg == DRAIN);
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//
// Self-checking bench for weight_loader (NUM_NODES=4, ADDR_WIDTH=4,
// DATA_WIDTH=16).
//
// A behavioural ROM with a one-cycle read latency feeds the design. On every
// expected issue, the bench pushes the expected {one-hot node, data} pair into
// a queue. On every observed FIFO write, it pops the head of that queue and
// compares.
// -----------------------------------------------------------------------------
module tb_weight_loader;
    localparam int NN = 4;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic [NN-1:0] full;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [NN-1:0] fifo_wr_en;
    logic [DW-1:0] fifo_wdata;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rom_mem [16];
    logic [NN-1:0] exp_en_q   [$];
    logic [DW-1:0] exp_data_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en === 1'b1) rom_data <= rom_mem[rom_addr];
    end

    weight_loader #(.NUM_NODES(NN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .full       (full),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .done       (done)
    );

    // Starts one transfer and follows it cycle by cycle against a reference
    // model. Model states: 0=RUN, 1=DRAIN, 2=DONE. Cycle c is the c-th cycle
    // after the edge that accepts start.
    task automatic run_xfer(input string name, input int base, input int num,
                            input int abort_cyc, input int restart_cyc,
                            input logic [NN-1:0] fmask, input int f_from, input int f_to,
                            output int done_cyc, output int n_wr);
        int            m_state, m_rem, m_node, m_addr;
        bit            prev_issue, exp_issue, ab;
        logic [NN-1:0] cur_full, exp_oh, got_oh;
        logic [DW-1:0] exp_d;
        exp_en_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        start     = 1'b1;
        abort     = 1'b0;
        full      = '0;
        base_addr = AW'(base);
        num_words = (AW + 1)'(num);
        m_state   = (num == 0) ? 2 : 0;
        m_rem     = num;
        m_node    = 0;
        m_addr    = base;
        prev_issue = 1'b0;
        done_cyc  = -1;
        n_wr      = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            cur_full  = (c >= f_from && c <= f_to) ? fmask : '0;
            ab        = (c == abort_cyc);
            full      = cur_full;
            abort     = ab;
            start     = (c == restart_cyc);
            base_addr = AW'(base + 7);
            num_words = (AW + 1)'(3);
            #1;
            exp_issue = (m_state == 0) && (m_rem > 0) && !cur_full[m_node] && !ab;
            total++;
            if (rom_en !== exp_issue)
                $display("FAIL %s rom_en cycle %0d: got %b want %b", name, c, rom_en, exp_issue);
            if (rom_en !== exp_issue) bad++;
            if (exp_issue && rom_en === 1'b1) begin
                total++;
                if (rom_addr !== AW'(m_addr)) begin
                    bad++;
                    $display("FAIL %s rom_addr cycle %0d: got %0d want %0d", name, c, rom_addr, m_addr);
                end
            end
            total++;
            if ((fifo_wr_en !== '0) !== prev_issue) begin
                bad++;
                $display("FAIL %s wr_present cycle %0d: got %b want write=%b", name, c, fifo_wr_en, prev_issue);
            end
            if (fifo_wr_en !== '0) begin
                n_wr++;
                total++;
                if (exp_en_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s write cycle %0d: got %b/%h want none", name, c, fifo_wr_en, fifo_wdata);
                end else begin
                    exp_oh = exp_en_q.pop_front();
                    exp_d  = exp_data_q.pop_front();
                    got_oh = fifo_wr_en;
                    if (got_oh !== exp_oh || fifo_wdata !== exp_d) begin
                        bad++;
                        $display("FAIL %s write cycle %0d: got %b/%h want %b/%h",
                                 name, c, got_oh, fifo_wdata, exp_oh, exp_d);
                    end
                end
            end
            total++;
            if (busy !== (m_state == 0 || m_state == 1)) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, (m_state < 2));
            end
            total++;
            if (done !== (m_state == 2)) begin
                bad++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, c, done, (m_state == 2));
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            prev_issue = exp_issue;
            if (exp_issue) begin
                exp_en_q.push_back(NN'(1) << m_node);
                exp_data_q.push_back(rom_mem[m_addr]);
                m_addr = (m_addr + 1) % 16;
                m_rem--;
                m_node = (m_node + 1) % NN;
            end
            if (m_state == 2) break;
            else if (m_state == 1) m_state = 2;
            else if (ab || (exp_issue && m_rem == 0)) m_state = 1;
        end
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL %s timeout: got no done want done", name);
        end
        total++;
        if (exp_en_q.size() != 0) begin
            bad++;
            $display("FAIL %s leftover: got %0d unwritten want 0", name, exp_en_q.size());
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        full  = '0;
        $display("xfer %s base=%0d num=%0d writes=%0d done_cycle=%0d", name, base, num, n_wr, done_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0; abort = 1'b0; full = '0; base_addr = '0; num_words = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({rom_en, fifo_wr_en, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset outputs: got %b want 0", {rom_en, fifo_wr_en, busy, done});
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset idle: got busy=%b done=%b want 0/0", busy, done);
        end
        $display("xfer reset released");
    endtask

    task automatic test_basic();
        int dc, nw;
        run_xfer("basic", 2, 6, 0, 0, '0, 0, 0, dc, nw);
        total++; if (dc != 8) begin bad++; $display("FAIL basic done_cycle: got %0d want 8", dc); end
        total++; if (nw != 6) begin bad++; $display("FAIL basic writes: got %0d want 6", nw); end
    endtask

    task automatic test_stall();
        int dc, nw;
        run_xfer("stall", 0, 4, 0, 0, 4'b0010, 2, 3, dc, nw);
        total++; if (dc != 8) begin bad++; $display("FAIL stall done_cycle: got %0d want 8", dc); end
        total++; if (nw != 4) begin bad++; $display("FAIL stall writes: got %0d want 4", nw); end
    endtask

    task automatic test_wrap();
        int dc, nw;
        run_xfer("wrap", 14, 4, 0, 0, '0, 0, 0, dc, nw);
        total++; if (dc != 6) begin bad++; $display("FAIL wrap done_cycle: got %0d want 6", dc); end
    endtask

    task automatic test_full_rom();
        int dc, nw;
        run_xfer("full_rom", 0, 16, 0, 0, '0, 0, 0, dc, nw);
        total++; if (dc != 18) begin bad++; $display("FAIL full_rom done_cycle: got %0d want 18", dc); end
        total++; if (nw != 16) begin bad++; $display("FAIL full_rom writes: got %0d want 16", nw); end
    endtask

    task automatic test_zero_words();
        int dc, nw;
        run_xfer("zero", 5, 0, 0, 0, '0, 0, 0, dc, nw);
        total++; if (dc != 1) begin bad++; $display("FAIL zero done_cycle: got %0d want 1", dc); end
        total++; if (nw != 0) begin bad++; $display("FAIL zero writes: got %0d want 0", nw); end
    endtask

    task automatic test_start_while_busy();
        int dc, nw;
        run_xfer("restart", 3, 5, 0, 2, '0, 0, 0, dc, nw);
        total++; if (dc != 7) begin bad++; $display("FAIL restart done_cycle: got %0d want 7", dc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (busy !== 1'b0 || rom_en !== 1'b0) begin
                bad++;
                $display("FAIL restart idle %0d: got busy=%b rom_en=%b want 0/0", i, busy, rom_en);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; base_addr = 4'd1; num_words = 5'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (busy !== 1'b0 || rom_en !== 1'b0 || done !== 1'b0 || fifo_wr_en !== '0) begin
                bad++;
                $display("FAIL start_abort %0d: got busy=%b rom_en=%b done=%b wr=%b want all 0",
                         i, busy, rom_en, done, fifo_wr_en);
            end
            @(negedge clk);
        end
        $display("xfer start_abort checked");
    endtask

    task automatic test_abort();
        int dc, nw;
        run_xfer("abort", 0, 8, 3, 0, '0, 0, 0, dc, nw);
        total++; if (dc != 5) begin bad++; $display("FAIL abort done_cycle: got %0d want 5", dc); end
        total++; if (nw != 2) begin bad++; $display("FAIL abort writes: got %0d want 2", nw); end
    endtask

    task automatic test_async_reset();
        int dc, nw;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd5; num_words = 5'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (rom_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL areset pre: got rom_en=%b busy=%b want 1/1", rom_en, busy);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({rom_en, fifo_wr_en, busy, done} !== '0) begin
            bad++;
            $display("FAIL areset outputs: got %b want 0", {rom_en, fifo_wr_en, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
        $display("xfer async reset applied mid-run");
        run_xfer("after_reset", 3, 5, 0, 0, '0, 0, 0, dc, nw);
        total++; if (dc != 7) begin bad++; $display("FAIL after_reset done_cycle: got %0d want 7", dc); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'(16'h5A3C ^ (i * 16'h0111));
        rom_data = '0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_full_rom();
        test_zero_words();
        test_start_while_busy();
        test_start_abort_idle();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/weight_loader.md
# weight_loader

Start-triggered sequencer that streams a contiguous run of weight words out of the synchronous weight ROM and distributes them in strict round-robin order (word k → node k mod NUM_NODES) into the per-node input FIFOs of the neural-net layer. It sits between the layer controller (start/abort/done handshake) and the ROM/FIFO datapath. It compensates for the ROM's one-cycle read latency and stalls in order on a per-node full flag. Word-to-node ordering is never reordered.

## Interface
- NUM_NODES, 4, number of node FIFOs; legal range 2..16.
- ADDR_WIDTH, 4, ROM address width; ROM depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 16, ROM/FIFO data width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately when low.
- start  in  1  one-cycle request, sampled only in IDLE.
- abort  in  1  stop the transfer early; sampled in RUN.
- base_addr  in  ADDR_WIDTH  first ROM address, latched on accepted start.
- num_words  in  ADDR_WIDTH+1  word count, latched on accepted start; 0..2^ADDR_WIDTH.
- full  in  NUM_NODES  per-node FIFO full flags.
- rom_en  out  1  ROM read strobe; combinational from registered state and full.
- rom_addr  out  ADDR_WIDTH  ROM read address; combinational, valid when rom_en=1.
- rom_data  in  DATA_WIDTH  ROM output; valid the cycle after rom_en.
- fifo_wr_en  out  NUM_NODES  one-hot write strobe, registered.
- fifo_wdata  out  DATA_WIDTH  equals rom_data (pass-through), qualified by fifo_wr_en.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse, registered.

## Operation
- State machine: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 latches base_addr into the address counter, num_words into the remaining counter, and clears node to 0.
  - The next state is RUN. If num_words=0, the next state is DONE instead.
  - start is ignored in every state except IDLE. If start and abort are both high in IDLE, the request is not accepted.
- RUN, issue rule: when remaining≠0 and full[node]=0, drive rom_en=1 and rom_addr=address counter. At the edge:
  - address counter +1, wrapping mod 2^ADDR_WIDTH;
  - remaining −1;
  - node +1, wrapping NUM_NODES−1 → 0;
  - the pending write register is loaded with one-hot(node).
- RUN, stall rule: when full[node]=1, rom_en=0 and the address counter, remaining and node all hold. There is no skipping to other nodes.
- RUN exit: when the last word issues (remaining goes 1→0), or when abort=1, the next state is DRAIN. When abort=1, rom_en is forced 0 in that cycle.
- DRAIN: lasts one cycle. rom_en=0, and the final pending write completes. The next state is DONE.
- DONE: done=1 and busy=0 for one cycle. The next state is IDLE.
- fifo_wr_en is 0 in any cycle whose previous cycle had no issue.
- Full-flag safety: because NUM_NODES≥2, successive writes to the same node are ≥NUM_NODES cycles apart. The full flag sampled at issue time therefore already reflects all earlier writes to that node.
- Reset (rst=0, any time including mid-transfer):
  - state returns to IDLE;
  - rom_en=0, fifo_wr_en=0, busy=0, done=0;
  - the address counter, remaining and node are all cleared;
  - an in-flight write is dropped.

## Timing
- Accepted start at edge E0: RUN is active in cycle 1, and busy=1 from cycle 1.
- Per word: rom_en in cycle c; fifo_wr_en and valid rom_data in cycle c+1; the FIFO captures the word at the end of cycle c+1.
- N words with no stalls: rom_en in cycles 1..N, writes in cycles 2..N+1, DRAIN in cycle N+1, done=1 and busy=0 in cycle N+2.
- Each stall cycle adds exactly one cycle to the total.
- num_words=0: done=1 in cycle 1, busy stays 0, and there is no ROM or FIFO activity.
- Abort in cycle a (state RUN): no issue in cycle a. The write from the cycle-(a−1) issue, if any, occurs in cycle a. DRAIN is cycle a+1 and done is in cycle a+2.
- Throughput: 1 word/cycle when no node is full.

## Test plan
- Basic stream (NUM_NODES=4, base=2, num=6, full=0, start at E0):
  - rom_addr 2..7 in cycles 1–6;
  - fifo_wr_en 0001, 0010, 0100, 1000, 0001, 0010 in cycles 2–7, each with fifo_wdata=ROM[addr];
  - done in cycle 8.
- Stall (base=0, num=4, full[1]=1 in cycles 2–3):
  - addr 0 issues in cycle 1;
  - no rom_en in cycles 2–3;
  - addr 1 issues in cycle 4 → node 1;
  - done in cycle 8;
  - order of words per node is preserved.
- Wrap (ADDR_WIDTH=4, base=14, num=4): rom_addr 14, 15, 0, 1 → nodes 0, 1, 2, 3.
- Full ROM (num=16, base=0): 16 writes, 4 per node; done in cycle 18.
- Edge requests:
  - num_words=0 gives done in cycle 1 with zero rom_en;
  - start while busy is ignored;
  - start together with abort in IDLE gives no transfer.
- Abort and reset:
  - abort in cycle 3 of a num=8 run gives exactly 2 writes (cycles 2–3), no write afterwards, done in cycle 5;
  - rst low mid-RUN clears all outputs asynchronously, and a fresh start afterwards begins again at node 0.
